// File: rtl/risc_pkg.sv
// Shared constants for the 16-bit RISC issue controller.
// Covers opcodes, instruction field slices, FSM state codes and opcode classes.
package risc_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_NOP  = 4'd8;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 0;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DECODE   = 3'd1;
   localparam logic [2:0] S_EXEC     = 3'd2;
   localparam logic [2:0] S_WAIT_MUL = 3'd3;
   localparam logic [2:0] S_WB       = 3'd4;
   localparam logic [2:0] S_HALTED   = 3'd5;

   typedef enum logic [2:0] {
      CLS_ALU     = 3'd0,
      CLS_MUL     = 3'd1,
      CLS_NOP     = 3'd2,
      CLS_HALT    = 3'd3,
      CLS_ILLEGAL = 3'd4
   } op_class_e;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode classifier: maps a 4-bit opcode to its execution class.
module risc_op_decode
   import risc_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_SLL, OP_SRL:           op_class = CLS_ALU;
         OP_MUL:                           op_class = CLS_MUL;
         OP_NOP:                           op_class = CLS_NOP;
         OP_HALT:                          op_class = CLS_HALT;
         default:                          op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/risc_issue_ctrl.sv
// Multi-cycle issue sequencer: accepts one instruction, walks it through
// DECODE/EXEC/(WAIT_MUL)/WB and drives register-file and ALU controls.
module risc_issue_ctrl
   import risc_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [15:0]      instruction,
   output logic             instr_ready,
   output logic [3:0]       rf_raddr_a,
   output logic [3:0]       rf_raddr_b,
   output logic [3:0]       alu_op,
   output logic             alu_start,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic             busy,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count
);

   // EXEC accounts for one MUL cycle, and WAIT_MUL exits on the cycle the counter reads zero.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

   logic [2:0]  state;
   logic [15:0] ir;
   logic [3:0]  mcnt;
   logic [2:0]  cls;
   logic [3:0]  ir_rd;

   risc_op_decode u_dec (
      .opcode   (ir[OPC_HI:OPC_LO]),
      .op_class (cls)
   );

   assign ir_rd = ir[RD_HI:RD_LO];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         ir            <= '0;
         mcnt          <= '0;
         retired_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  ir    <= instruction;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (cls)
                  CLS_ALU, CLS_MUL: state <= S_EXEC;
                  CLS_NOP: begin
                     state         <= S_IDLE;
                     retired_count <= retired_count + CNT_W'(1);
                  end
                  CLS_HALT: begin
                     state         <= S_HALTED;
                     retired_count <= retired_count + CNT_W'(1);
                  end
                  default: state <= S_IDLE;
               endcase
            end
            S_EXEC: begin
               if (cls == CLS_MUL) begin
                  mcnt  <= MUL_LOAD;
                  state <= S_WAIT_MUL;
               end else begin
                  state <= S_WB;
               end
            end
            S_WAIT_MUL: begin
               if (mcnt == 4'd0) state <= S_WB;
               else              mcnt  <= mcnt - 4'd1;
            end
            S_WB: begin
               // R0 writes are suppressed on rf_we but still count as retired.
               retired_count <= retired_count + CNT_W'(1);
               state         <= S_IDLE;
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Everything below is decoded from state and IR only; no path from instruction.
   assign busy        = (state == S_DECODE) || (state == S_EXEC) ||
                        (state == S_WAIT_MUL) || (state == S_WB);
   assign instr_ready = (state == S_IDLE) && !rst;
   assign halted      = (state == S_HALTED);
   assign rf_raddr_a  = busy ? ir[RS1_HI:RS1_LO] : 4'h0;
   assign rf_raddr_b  = busy ? ir[RS2_HI:RS2_LO] : 4'h0;
   assign alu_op      = ((state == S_EXEC) || (state == S_WAIT_MUL)) ? ir[OPC_HI:OPC_LO] : 4'h0;
   assign alu_start   = (state == S_EXEC);
   assign rf_waddr    = (state == S_WB) ? ir_rd : 4'h0;
   assign rf_we       = (state == S_WB) && (ir_rd != 4'h0);
   assign illegal     = (state == S_DECODE) && (cls == CLS_ILLEGAL);

endmodule

// File: doc/risc_issue_ctrl.md
Name: risc_issue_ctrl

Overview:
Multi-cycle control sequencer for the 16-bit RISC datapath. It accepts one instruction word through a valid/ready handshake and decodes the opcode. It then steps the instruction through DECODE, EXEC and WRITEBACK, driving the register-file read/write addresses, the ALU opcode and start strobe, and the writeback enable. It also owns multi-cycle MUL timing, illegal-opcode flagging, HALT and a retired-instruction counter.

Parameters:
MUL_CYCLES, 4, EXEC+WAIT_MUL cycles for MUL (legal range 2..15)
CNT_W, 16, width of retired_count

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction word present
instruction  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
instr_ready  out  1  controller can accept an instruction this cycle
rf_raddr_a  out  4  register-file read port A address (rs1)
rf_raddr_b  out  4  register-file read port B address (rs2)
alu_op  out  4  ALU operation select (opcode of the in-flight instruction)
alu_start  out  1  one-cycle strobe, first EXEC cycle
rf_we  out  1  register-file write enable, one cycle
rf_waddr  out  4  write address (rd)
busy  out  1  high in every state except IDLE and HALTED
illegal  out  1  one-cycle pulse on an illegal opcode
halted  out  1  high in HALTED
retired_count  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: single-cycle ALU ops.
  - 7 MUL: multi-cycle.
  - 8 NOP.
  - 15 HALT.
  - 9-14: illegal.
- States: IDLE, DECODE, EXEC, WAIT_MUL, WB, HALTED.
- Reset (rst=1 at an edge): state=IDLE; IR, all address/op outputs, alu_start, rf_we, illegal and retired_count go to 0. Reset mid-instruction aborts it with no write and no retire.
- instr_ready = (state==IDLE) and not rst. A transfer happens when instr_valid and instr_ready are both high at an edge; IR is captured and the state moves to DECODE.
- DECODE: rf_raddr_a/b = IR rs1/rs2, held until the return to IDLE. Transitions:
  - ALU ops and MUL go to EXEC.
  - NOP goes to IDLE; retired_count+1.
  - Illegal goes to IDLE; illegal pulses 1 cycle; no retire.
  - HALT goes to HALTED; retired_count+1.
- EXEC: alu_op = IR opcode; alu_start=1 for this cycle only. Single-cycle ops go to WB; MUL goes to WAIT_MUL with the counter loaded to MUL_CYCLES-2.
- WAIT_MUL: alu_op is held. When the counter is 0, go to WB; otherwise decrement.
- WB: rf_we=1 and rf_waddr=rd. If rd==0, rf_we stays 0 (R0 is hardwired zero) but the instruction still retires. retired_count+1. Next state is IDLE.
- HALTED: instr_ready=0 and halted=1 until rst; instr_valid is ignored.
- Latency, with the handshake at edge t0:
  - ALU op: rf_we high in cycle t0+3.
  - MUL: rf_we high in cycle t0+2+MUL_CYCLES (t0+6 at the default).
- Throughput: the next accept happens in the IDLE cycle after WB. An ALU op occupies 4 cycles, a MUL 3+MUL_CYCLES cycles.
- instruction is sampled only at the handshake; changes while busy have no effect.
- retired_count wraps from all-ones to 0 without a flag.
- All outputs are registered or decoded from state/IR only, with no combinational path from instruction.

Decomposition:
- Package risc_pkg holds:
  - opcode constants OP_ADD..OP_MUL, OP_NOP, OP_HALT;
  - the state enum;
  - field-slice constants for rd/rs1/rs2.
- One combinational sub-module, risc_op_decode: opcode in, class out (ALU, MUL, NOP, HALT, ILLEGAL).
- The FSM, counter and output registers live in risc_issue_ctrl.

Test Plan:
- ADD R1,R2,R3 (16'h0123) accepted at t0: raddr_a=2 and raddr_b=3 from t0+1; alu_start=1 and alu_op=0 at t0+2; rf_we=1 with waddr=1 at t0+3; retired_count=1; instr_ready=1 at t0+4.
- MUL R4,R5,R6 (16'h7456) with MUL_CYCLES=4: alu_start at t0+2 only; rf_we=1 with waddr=4 at t0+6; busy high t0+1..t0+6.
- Back-to-back with instr_valid held high (16'h0123 then 16'h1123): second accept at t0+4; second rf_we at t0+7; alu_op=1 at t0+6.
- 16'h9000: illegal pulses at t0+1; rf_we never asserts; retired_count unchanged. Then ADD with rd=0 (16'h0012): rf_we stays 0 and retired_count increments.
- HALT 16'hF000: halted=1 and instr_ready=0 from t0+2; later instr_valid is ignored. Asserting rst for 1 cycle returns to IDLE with retired_count=0.
- rst asserted during WAIT_MUL: no rf_we; state IDLE after the reset edge; all outputs 0 except instr_ready=1 once rst is low.
